// File: rtl/l2_cacheline_adaptor.sv
// l2_cacheline_adaptor
// Bridges a cache that moves whole lines to a memory port that moves one
// beat per acknowledge. A line fill is assembled beat by beat into
// line_rdata; a writeback is latched once and streamed out beat by beat.
//
// Build option:
//   L2_ADAPTOR_FAST_RESP_EN - drops the DONE state. line_resp is raised
//   combinationally in the cycle of the last beat acknowledge, and the last
//   read beat is forwarded straight onto the top slice of line_rdata.
module l2_cacheline_adaptor #(
   parameter int s_line  = 256,
   parameter int s_burst = 64
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                line_read,
   input  logic                line_write,
   input  logic [31:0]         line_address,
   input  logic [s_line-1:0]   line_wdata,
   output logic [s_line-1:0]   line_rdata,
   output logic                line_resp,
   output logic                burst_read,
   output logic                burst_write,
   output logic [31:0]         burst_address,
   output logic [s_burst-1:0]  burst_wdata,
   input  logic [s_burst-1:0]  burst_rdata,
   input  logic                burst_resp
);

   localparam int beats = s_line / s_burst;
   localparam int cnt_w = (beats > 1) ? $clog2(beats) : 1;
   localparam int off_w = $clog2(s_line / 8);
   localparam logic [cnt_w-1:0] last_beat = cnt_w'(beats - 1);

`ifdef L2_ADAPTOR_FAST_RESP_EN
   typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, DONE = 2'd3} state_t;
`endif

   state_t                 state, state_next;
   logic [cnt_w-1:0]       cnt;
   logic [31:off_w]        addr_q;
   logic [s_line-1:0]      wdata_q;
   logic [s_line-1:0]      rdata_q;
   logic                   beat_take;
   logic                   last_take;
   logic                   leave_idle;
   logic                   unused_addr_bits;

   // Byte offset within the line never reaches memory; bursts are line aligned.
   assign unused_addr_bits = ^line_address[off_w-1:0];

   assign beat_take  = burst_resp && ((state == READ) || (state == WRITE));
   assign last_take  = beat_take && (cnt == last_beat);
   assign leave_idle = (state == IDLE) && (line_read || line_write);

   assign burst_address = {addr_q, {off_w{1'b0}}};
   assign burst_wdata   = wdata_q[s_burst*int'(cnt) +: s_burst];

   // Next-state selection; a write request takes priority over a read.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (line_write)
               state_next = WRITE;
            else if (line_read)
               state_next = READ;
         end
         READ, WRITE: begin
`ifdef L2_ADAPTOR_FAST_RESP_EN
            if (last_take)
               state_next = IDLE;
`else
            if (last_take)
               state_next = DONE;
`endif
         end
         default: state_next = IDLE;
      endcase
   end

   // State register plus registered burst strobes that mirror the next state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         burst_read  <= 1'b0;
         burst_write <= 1'b0;
      end else begin
         state       <= state_next;
         burst_read  <= (state_next == READ);
         burst_write <= (state_next == WRITE);
      end
   end

   // Beat counter: cleared while idle, advanced on each accepted beat, wraps after the last.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         cnt <= '0;
      else if (state == IDLE)
         cnt <= '0;
      else if (beat_take)
         cnt <= cnt + 1'b1;
   end

   // Request capture on leaving IDLE so upstream changes mid-burst are ignored.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (leave_idle) begin
         addr_q <= line_address[31:off_w];
         if (line_write)
            wdata_q <= line_wdata;
      end
   end

   // Fill line assembly; only read beats touch it, so it holds across writes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         rdata_q <= '0;
      else if ((state == READ) && burst_resp)
         rdata_q[s_burst*int'(cnt) +: s_burst] <= burst_rdata;
   end

`ifdef L2_ADAPTOR_FAST_RESP_EN
   assign line_resp = last_take;

   // Forward the final read beat so the full line is visible with line_resp.
   always_comb begin
      line_rdata = rdata_q;
      if ((state == READ) && last_take)
         line_rdata[s_line-1 -: s_burst] = burst_rdata;
   end
`else
   assign line_resp  = (state == DONE);
   assign line_rdata = rdata_q;
`endif

endmodule

// File: tb/tb_l2_cacheline_adaptor.sv
// tb_l2_cacheline_adaptor
// Directed bench for l2_cacheline_adaptor: reads, writes with idle gaps,
// read/write collision, mid-burst reset and spurious/upstream disturbances.
// Honours L2_ADAPTOR_FAST_RESP_EN for response timing.
module tb_l2_cacheline_adaptor;

   logic          clk;
   logic          rst;
   logic          line_read;
   logic          line_write;
   logic [31:0]   line_address;
   logic [255:0]  line_wdata;
   logic [255:0]  line_rdata;
   logic          line_resp;
   logic          burst_read;
   logic          burst_write;
   logic [31:0]   burst_address;
   logic [63:0]   burst_wdata;
   logic [63:0]   burst_rdata;
   logic          burst_resp;

   int n_checks;
   int n_errors;

   localparam logic [255:0] line_a = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                      64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
   localparam logic [255:0] line_b = {64'h8888_0000_8888_0000, 64'h7777_0000_7777_0000,
                                      64'h6666_0000_6666_0000, 64'h5555_0000_5555_0000};
   localparam logic [255:0] line_c = {64'hCAFE_0003_CAFE_0003, 64'hCAFE_0002_CAFE_0002,
                                      64'hCAFE_0001_CAFE_0001, 64'hCAFE_0000_CAFE_0000};
   localparam logic [255:0] wr_d   = {64'hD3D3_D3D3_0000_0003, 64'hD2D2_D2D2_0000_0002,
                                      64'hD1D1_D1D1_0000_0001, 64'hD0D0_D0D0_0000_0000};
   localparam logic [255:0] wr_e   = {64'hE3E3_0000_0000_E3E3, 64'hE2E2_0000_0000_E2E2,
                                      64'hE1E1_0000_0000_E1E1, 64'hE0E0_0000_0000_E0E0};

   l2_cacheline_adaptor dut (
      .clk           (clk),
      .rst           (rst),
      .line_read     (line_read),
      .line_write    (line_write),
      .line_address  (line_address),
      .line_wdata    (line_wdata),
      .line_rdata    (line_rdata),
      .line_resp     (line_resp),
      .burst_read    (burst_read),
      .burst_write   (burst_write),
      .burst_address (burst_address),
      .burst_wdata   (burst_wdata),
      .burst_rdata   (burst_rdata),
      .burst_resp    (burst_resp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full line read; optional idle cycle before each beat and optional
   // upstream address/data disturbance right after the request is taken.
   task automatic run_read(input string tag, input logic [31:0] addr, input logic [255:0] line,
                           input bit gaps, input bit disturb);
      logic [31:0] exp_addr;
      exp_addr     = {addr[31:5], 5'b0};
      line_read    = 1'b1;
      line_write   = 1'b0;
      line_address = addr;
      burst_resp   = 1'b0;
      tick();
      check_val({tag, ".burst_read"}, burst_read, 1'b1);
      check_val({tag, ".burst_write"}, burst_write, 1'b0);
      check_val({tag, ".addr"}, burst_address, exp_addr);
      if (disturb) begin
         line_address = ~addr;
         line_wdata   = wr_e;
      end
      for (int i = 0; i < 4; i++) begin
         if (gaps) begin
            burst_resp  = 1'b0;
            burst_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
            tick();
            check_val({tag, ".gap_resp"}, line_resp, 1'b0);
            check_val({tag, ".gap_addr"}, burst_address, exp_addr);
         end
         burst_resp  = 1'b1;
         burst_rdata = line[64*i +: 64];
         if (i == 3) begin
`ifdef L2_ADAPTOR_FAST_RESP_EN
            check_val({tag, ".fast_resp"}, line_resp, 1'b1);
            check_val({tag, ".fast_line"}, line_rdata, line);
`else
            check_val({tag, ".early_resp"}, line_resp, 1'b0);
`endif
         end
         tick();
      end
      burst_resp  = 1'b0;
      burst_rdata = '0;
`ifdef L2_ADAPTOR_FAST_RESP_EN
      check_val({tag, ".resp_after"}, line_resp, 1'b0);
`else
      check_val({tag, ".resp"}, line_resp, 1'b1);
`endif
      check_val({tag, ".line"}, line_rdata, line);
      check_val({tag, ".rd_drop"}, burst_read, 1'b0);
      line_read = 1'b0;
      tick();
      check_val({tag, ".resp_end"}, line_resp, 1'b0);
      check_val({tag, ".line_hold"}, line_rdata, line);
   endtask

   initial begin
      n_checks     = 0;
      n_errors     = 0;
      rst          = 1'b0;
      line_read    = 1'b0;
      line_write   = 1'b0;
      line_address = '0;
      line_wdata   = '0;
      burst_rdata  = '0;
      burst_resp   = 1'b0;
      tick();
      tick();
      check_val("rst.line_resp", line_resp, 1'b0);
      check_val("rst.burst_read", burst_read, 1'b0);
      check_val("rst.burst_write", burst_write, 1'b0);
      check_val("rst.burst_address", burst_address, 32'h0);
      check_val("rst.burst_wdata", burst_wdata, 64'h0);
      check_val("rst.line_rdata", line_rdata, 256'h0);

      // Read right after reset release: request taken on the first edge.
      rst = 1'b1;
      run_read("rd1", 32'h0000_1234, line_a, 1'b0, 1'b0);

      // Write with burst_resp low on alternate cycles.
      line_write   = 1'b1;
      line_address = 32'h8000_0040;
      line_wdata   = wr_d;
      tick();
      check_val("wr.burst_write", burst_write, 1'b1);
      check_val("wr.burst_read", burst_read, 1'b0);
      check_val("wr.addr", burst_address, 32'h8000_0040);
      line_address = 32'h0000_0000;
      line_wdata   = wr_e;
      for (int i = 0; i < 4; i++) begin
         burst_resp = 1'b0;
         check_val("wr.wdata_gap", burst_wdata, wr_d[64*i +: 64]);
         tick();
         check_val("wr.wdata_hold", burst_wdata, wr_d[64*i +: 64]);
         burst_resp = 1'b1;
`ifdef L2_ADAPTOR_FAST_RESP_EN
         check_val("wr.fast_resp", line_resp, (i == 3) ? 1'b1 : 1'b0);
`else
         check_val("wr.no_resp", line_resp, 1'b0);
`endif
         tick();
      end
      burst_resp = 1'b0;
`ifdef L2_ADAPTOR_FAST_RESP_EN
      check_val("wr.resp_after", line_resp, 1'b0);
`else
      check_val("wr.resp", line_resp, 1'b1);
`endif
      check_val("wr.rdata_kept", line_rdata, line_a);
      check_val("wr.wr_drop", burst_write, 1'b0);
      line_write = 1'b0;
      tick();
      check_val("wr.resp_end", line_resp, 1'b0);

      // Simultaneous read and write: the write wins.
      line_read    = 1'b1;
      line_write   = 1'b1;
      line_address = 32'h0000_0100;
      line_wdata   = wr_e;
      tick();
      for (int i = 0; i < 4; i++) begin
         check_val("both.burst_write", burst_write, 1'b1);
         check_val("both.burst_read", burst_read, 1'b0);
         check_val("both.wdata", burst_wdata, wr_e[64*i +: 64]);
         burst_resp = 1'b1;
         tick();
      end
      burst_resp = 1'b0;
      check_val("both.addr", burst_address, 32'h0000_0100);
      check_val("both.burst_read_end", burst_read, 1'b0);
      line_read  = 1'b0;
      line_write = 1'b0;
      tick();

      // Reset after two beats of a read aborts it without a response.
      line_read    = 1'b1;
      line_address = 32'h0000_2000;
      tick();
      check_val("abort.burst_read", burst_read, 1'b1);
      for (int i = 0; i < 2; i++) begin
         burst_resp  = 1'b1;
         burst_rdata = line_c[64*i +: 64];
         tick();
      end
      #2;
      rst = 1'b0;
      #1;
      check_val("abort.burst_read", burst_read, 1'b0);
      check_val("abort.line_resp", line_resp, 1'b0);
      check_val("abort.line_rdata", line_rdata, 256'h0);
      check_val("abort.addr", burst_address, 32'h0);
      burst_resp = 1'b0;
      line_read  = 1'b0;
      tick();
      check_val("abort.resp_held", line_resp, 1'b0);
      rst = 1'b1;
      run_read("rd2", 32'h0000_3010, line_b, 1'b0, 1'b0);

      // Spurious acknowledges in IDLE change nothing.
      burst_resp = 1'b1;
      tick();
      tick();
      check_val("idle.burst_read", burst_read, 1'b0);
      check_val("idle.burst_write", burst_write, 1'b0);
      check_val("idle.line_resp", line_resp, 1'b0);
      check_val("idle.addr", burst_address, 32'h0000_3000);
      check_val("idle.line", line_rdata, line_b);
      burst_resp = 1'b0;

      // Gapped read with upstream address change after the request is taken.
      run_read("rd3", 32'h0000_4008, line_c, 1'b1, 1'b1);
      check_val("rd3.addr_kept", burst_address, 32'h0000_4000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
